seq_divider: RTL
================

Name: seq_divider

Overview:
- Sequential radix-2 restoring divider. It is the inverse companion of the team's sequential 64x64 multiplier.
- Uses the same op_start / op_clear / op_done handshake, so the same controller and bench style drive both blocks.
- Produces quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit.

Parameters:
- WIDTH, 64, operand, quotient and remainder width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset.
- dividend  input  WIDTH  numerator; sampled only on the accepting edge.
- divisor  input  WIDTH  denominator; sampled only on the accepting edge.
- op_start  input  1  request operation (level).
- op_clear  input  1  return to IDLE and zero all outputs (level).
- op_done  output  1  result valid; held until op_clear.
- quotient  output  WIDTH  quotient.
- remainder  output  WIDTH  remainder.
- div_by_zero  output  1  set with op_done when the latched divisor was 0.

Clocking and reset (already decided): one clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.

Behaviour:
- Reset (reset=1 at a clk edge) overrides everything:
  - state=IDLE, counter=0, op_done=0, div_by_zero=0, quotient=0, remainder=0, internal registers=0.
  - Reset mid-operation aborts the operation with no partial result.
- Priority at each edge: reset > op_clear > op_start > iteration.
- States:
  - IDLE: op_start=1 latches dividend and divisor. If divisor!=0, go to BUSY with counter=0 and partial remainder=0. If divisor==0, go to DONE.
  - BUSY: one restoring step per cycle:
    - shift {rem,quo} left by 1, bringing in the next dividend MSB;
    - trial = rem - divisor;
    - if trial is non-negative (no borrow), rem=trial and the quotient bit is 1; else the quotient bit is 0.
    - After WIDTH steps (counter==WIDTH-1), go to DONE and load the quotient/remainder outputs.
  - DONE: op_done=1 and outputs stable. op_start is ignored, including when held high, so there is no auto-restart. op_clear=1 sends the block to IDLE.
- op_clear in any state (not reset): next state IDLE; op_done, div_by_zero, quotient and remainder all cleared to 0. op_clear together with op_start is resolved as clear.
- Latency:
  - op_start sampled at edge E0 → op_done=1 after edge E(WIDTH); E64 for the default.
  - Divide-by-zero: op_done=1 after E1.
- Divide-by-zero result: quotient = all ones, remainder = latched dividend, div_by_zero=1.
- Operands changing during BUSY have no effect.
- Outputs are 0 whenever op_done=0.
- Arithmetic: unsigned. The subtractor is WIDTH+1 bits wide so the borrow is explicit. Quotient never exceeds dividend, so no overflow is possible.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at accept and fed to the same unsigned core.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - MIN / -1 → quotient=MIN, remainder=0, no flag.
  - Divide-by-zero behaves as in unsigned mode.
  - Latency is unchanged: sign fix-up is combinational into the DONE load.
- Undefined: pure unsigned; no sign logic is synthesized.

Decomposition:
- Package seq_divider_pkg:
  - state enum (IDLE, BUSY, DONE);
  - DIV_WIDTH_DEFAULT=64;
  - function returning the divide-by-zero quotient constant.
- One sub-module: div_step, a combinational single restoring step.
  - Inputs: rem_in, dividend bit in, divisor.
  - Outputs: rem_out, q_bit.
- Top level holds the FSM, counter, operand registers and sign fix-up.

Test Plan:
- dividend=12, divisor=4, op_start held high → op_done rises exactly 64 cycles after the accepting edge; quotient=3, remainder=0; op_done stays high while op_start stays high; op_clear → all outputs 0 next cycle.
- dividend=100, divisor=7 → quotient=14, remainder=2. dividend=2^64-1, divisor=1 → quotient=2^64-1, remainder=0.
- dividend=55, divisor=0 → op_done and div_by_zero high after 1 cycle; quotient=all ones, remainder=55.
- Abort mid-operation: op_clear at cycle 30 of BUSY → IDLE with outputs 0; a new op_start with 9/3 then completes normally with quotient=3, remainder=0. Separately, reset at cycle 30 of BUSY → same abort.
- Operand stability: divisor changed to 1 during BUSY → result still reflects the latched operands.
- Simultaneous op_start and op_clear → stays IDLE.
- With SEQ_DIVIDER_SIGNED_EN: -7/2 → quotient=-3, remainder=-1; 7/-2 → quotient=-3, remainder=1; MIN/-1 → quotient=MIN, remainder=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional two's-complement mode is selected with SEQ_DIVIDER_SIGNED_EN.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 64;

  // Widest datapath the divide-by-zero constant covers; callers cast down.
  localparam int DIV_WIDTH_MAX = 256;

  function automatic logic [DIV_WIDTH_MAX-1:0] dbz_quotient();
    return '1;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  assign shifted = {rem_in[WIDTH-2:0], dividend_bit};
  assign trial   = {1'b0, shifted} - {1'b0, divisor};

  // rem_in < divisor, so a bit shifted out of the top means the true
  // difference is positive even though the low WIDTH+1 bits borrowed.
  assign q_bit   = rem_in[WIDTH-1] | ~trial[WIDTH];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted;

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider with op_start/op_clear/op_done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op_start,
  input  logic             op_clear,
  output logic             op_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             done_reg;
  logic             dbz_reg;

  logic             accept;
  logic             step;
  logic             finish;
  logic             dbz_load;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_reg;
  logic neg_r_reg;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign q_final = neg_q_reg ? -quo_next : quo_next;
  assign r_final = neg_r_reg ? -step_rem : step_rem;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_final = quo_next;
  assign r_final = step_rem;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (rem_reg),
    .dividend_bit(quo_reg[WIDTH-1]),
    .divisor     (divisor_reg),
    .rem_out     (step_rem),
    .q_bit       (step_q)
  );

  // The dividend shifts out of quo_reg's top while quotient bits enter its bottom.
  assign quo_next = {quo_reg[WIDTH-2:0], step_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (op_clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (op_start) state_next = (divisor == '0) ? DONE : BUSY;
        BUSY:    if (cnt_reg == LAST_CNT) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A zero divisor enters DONE with op_done still low; the result is
  // published on the following edge, giving the one-cycle flagged latency.
  always_comb begin
    accept   = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    dbz_load = 1'b0;
    if (!op_clear) begin
      case (state_reg)
        IDLE: accept = op_start;
        BUSY: begin
          step   = 1'b1;
          finish = (cnt_reg == LAST_CNT);
        end
        DONE:    dbz_load = ~done_reg;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || op_clear) begin
      cnt_reg       <= '0;
      divisor_reg   <= '0;
      quo_reg       <= '0;
      rem_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
`endif
    end else if (accept) begin
      cnt_reg     <= '0;
      divisor_reg <= dvs_mag;
      quo_reg     <= dvd_mag;
      // Raw dividend parked here is the divide-by-zero remainder.
      rem_reg     <= (divisor == '0) ? dividend : '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_reg   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_reg   <= dividend[WIDTH-1];
`endif
    end else if (step) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      quo_reg <= quo_next;
      rem_reg <= step_rem;
      if (finish) begin
        done_reg      <= 1'b1;
        quotient_reg  <= q_final;
        remainder_reg <= r_final;
      end
    end else if (dbz_load) begin
      done_reg      <= 1'b1;
      dbz_reg       <= 1'b1;
      quotient_reg  <= WIDTH'(dbz_quotient());
      remainder_reg <= rem_reg;
    end
  end

  assign op_done     = done_reg;
  assign div_by_zero = dbz_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;

endmodule
